divider: RTL and testbench

- Sequential restoring shift-subtract divider; the inverse of the team's shift-add multiplier.
- Takes a 2*BITS dividend and a BITS divisor; returns a BITS quotient and a BITS remainder.
- Issues one quotient bit per clock.
- Used in the arithmetic datapath alongside the multiplier, with the same start/finished control style.

---
 rtl/divider_pkg.sv | 15 +
 rtl/divider_step.sv | 24 ++
 rtl/divider.sv | 105 ++++++++++
 tb/tb_divider.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the restoring shift-subtract divider.
package divider_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Wide enough to hold BITS itself, not just BITS-1.
   function automatic int cnt_width(input int bits);
      return $clog2(bits) + 1;
   endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: trial subtract of D from T, restore on borrow.
// Purely combinational.
module divider_step #(
   parameter int BITS = 8
) (
   input  logic [BITS:0]   t_i,
   input  logic [BITS-1:0] d_i,
   output logic [BITS-1:0] r_o,
   output logic            q_o
);

   logic [BITS+1:0] sum;
   logic [BITS+1:0] addend;
   logic [BITS+1:0] carry_in;

   // T + ~D + 1 at BITS+1 bits; the carry out of that width means no borrow.
   assign addend   = {1'b0, ~{1'b0, d_i}};
   assign carry_in = {{(BITS+1){1'b0}}, 1'b1};
   assign sum      = {1'b0, t_i} + addend + carry_in;

   assign q_o = sum[BITS+1];
   assign r_o = q_o ? sum[BITS-1:0] : t_i[BITS-1:0];

endmodule

// File: rtl/divider.sv
// Sequential restoring divider: 2*BITS / BITS, one quotient bit per clock.
// BITS+1 cycles start to o_finished (1 on error); starts during RUN are dropped.
module divider
   import divider_pkg::*;
#(
   parameter int BITS = 8
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_finished,
   output logic              o_divide_by_zero,
   output logic              o_overflow,
   input  logic [2*BITS-1:0] i_dividend,
   input  logic [BITS-1:0]   i_divisor,
   output logic [BITS-1:0]   o_quotient,
   output logic [BITS-1:0]   o_remainder
);

   localparam int            CW   = cnt_width(BITS);
   localparam logic [CW-1:0] LAST = CW'(BITS - 1);

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [BITS-1:0] r_q;
   logic [BITS-1:0] q_q;
   logic [BITS-1:0] d_q;
   logic            busy_q;
   logic            fin_q;
   logic            dbz_q;
   logic            ovf_q;

   logic [BITS-1:0] r_d;
   logic            qbit_d;
   logic [BITS-1:0] in_hi;

   assign in_hi = i_dividend[2*BITS-1:BITS];

   divider_step #(.BITS(BITS)) u_step (
      .t_i (({r_q, q_q[BITS-1]})),
      .d_i (d_q),
      .r_o (r_d),
      .q_o (qbit_d)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               r_q   <= r_d;
               q_q   <= {q_q[BITS-2:0], qbit_d};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  fin_q   <= 1'b1;
               end
            end
            default: begin
               fin_q   <= 1'b0;
               state_q <= S_IDLE;
               if (i_start) begin
                  d_q   <= i_divisor;
                  cnt_q <= '0;
                  dbz_q <= 1'b0;
                  ovf_q <= 1'b0;
                  // Errors finish immediately with a saturated quotient.
                  if (i_divisor == '0 || in_hi >= i_divisor) begin
                     dbz_q   <= (i_divisor == '0);
                     ovf_q   <= (i_divisor != '0);
                     q_q     <= '1;
                     r_q     <= '0;
                     state_q <= S_DONE;
                     fin_q   <= 1'b1;
                  end else begin
                     r_q     <= in_hi;
                     q_q     <= i_dividend[BITS-1:0];
                     state_q <= S_RUN;
                     busy_q  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign o_busy           = busy_q;
   assign o_finished       = fin_q;
   assign o_divide_by_zero = dbz_q;
   assign o_overflow       = ovf_q;
   assign o_quotient       = q_q;
   assign o_remainder      = r_q;

endmodule

// File: tb/tb_divider.sv
// Randomised and directed checks of divider against a plain-arithmetic model.
module tb_divider;

   localparam int BITS = 8;

   logic              i_clock = 1'b0;
   logic              i_reset = 1'b1;
   logic              i_start = 1'b0;
   logic              o_busy;
   logic              o_finished;
   logic              o_divide_by_zero;
   logic              o_overflow;
   logic [2*BITS-1:0] i_dividend = '0;
   logic [BITS-1:0]   i_divisor = '0;
   logic [BITS-1:0]   o_quotient;
   logic [BITS-1:0]   o_remainder;

   int checks = 0;
   int errors = 0;

   always #5 i_clock = ~i_clock;

   divider #(.BITS(BITS)) dut (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_start          (i_start),
      .o_busy           (o_busy),
      .o_finished       (o_finished),
      .o_divide_by_zero (o_divide_by_zero),
      .o_overflow       (o_overflow),
      .i_dividend       (i_dividend),
      .i_divisor        (i_divisor),
      .o_quotient       (o_quotient),
      .o_remainder      (o_remainder)
   );

   // Reference: plain integer division with the saturating error rules.
   task automatic model(input logic [2*BITS-1:0] dvd, input logic [BITS-1:0] dvs,
                        output logic [BITS-1:0] q, output logic [BITS-1:0] r,
                        output logic dbz, output logic ovf, output int lat);
      int unsigned nd, ns;
      nd = dvd;
      ns = dvs;
      dbz = (ns == 0);
      ovf = !dbz && ((nd >> BITS) >= ns);
      if (dbz || ovf) begin
         q = '1; r = '0; lat = 1;
      end else begin
         q = BITS'(nd / ns); r = BITS'(nd % ns); lat = BITS + 1;
      end
   endtask

   // Drive one start pulse; returns at the negedge after the accepting edge.
   task automatic start_op(input logic [2*BITS-1:0] dvd, input logic [BITS-1:0] dvs);
      @(negedge i_clock);
      i_start = 1'b1; i_dividend = dvd; i_divisor = dvs;
      @(negedge i_clock);
      i_start = 1'b0;
   endtask

   // Cycles from the accepting edge until o_finished, bounded at 40.
   task automatic wait_finished(output int cyc, output int busy_n);
      cyc = 1;
      busy_n = 0;
      while (!o_finished && cyc < 40) begin
         if (o_busy) busy_n++;
         @(negedge i_clock);
         cyc++;
      end
   endtask

   task automatic test_reset;
      i_reset = 1'b1;
      repeat (2) @(negedge i_clock);
      checks++;
      if ({o_busy, o_finished, o_divide_by_zero, o_overflow, o_quotient, o_remainder} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b fin=%b dbz=%b ovf=%b q=%0d r=%0d, want all 0",
                  o_busy, o_finished, o_divide_by_zero, o_overflow, o_quotient, o_remainder);
      end
      i_reset = 1'b0;
      @(negedge i_clock);
   endtask

   task automatic test_basic;
      int cyc, busy_n;
      start_op(16'd100, 8'd7);
      wait_finished(cyc, busy_n);
      checks++;
      if (cyc !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", cyc); end
      checks++;
      if (busy_n !== 8) begin errors++; $display("FAIL basic_busy: got %0d want 8", busy_n); end
      checks++;
      if (o_quotient !== 8'd14 || o_remainder !== 8'd2) begin
         errors++; $display("FAIL basic_result: got %0d r %0d want 14 r 2", o_quotient, o_remainder);
      end
      checks++;
      if (o_divide_by_zero !== 1'b0 || o_overflow !== 1'b0) begin
         errors++; $display("FAIL basic_flags: got dbz=%b ovf=%b want 0 0", o_divide_by_zero, o_overflow);
      end
   endtask

   task automatic test_boundary;
      int cyc, busy_n;
      start_op(16'hFEFF, 8'hFF);
      wait_finished(cyc, busy_n);
      checks++;
      if (o_quotient !== 8'hFF || o_remainder !== 8'hFE || o_overflow !== 1'b0 || cyc !== 9) begin
         errors++;
         $display("FAIL boundary: got q=%h r=%h ovf=%b lat=%0d want q=ff r=fe ovf=0 lat=9",
                  o_quotient, o_remainder, o_overflow, cyc);
      end
   endtask

   task automatic test_overflow;
      int cyc, busy_n;
      start_op(16'h1000, 8'h10);
      wait_finished(cyc, busy_n);
      checks++;
      if (cyc !== 1 || o_overflow !== 1'b1 || o_divide_by_zero !== 1'b0) begin
         errors++; $display("FAIL overflow_flag: got lat=%0d ovf=%b dbz=%b want 1 1 0", cyc, o_overflow, o_divide_by_zero);
      end
      checks++;
      if (o_quotient !== 8'hFF || o_remainder !== 8'h00) begin
         errors++; $display("FAIL overflow_result: got q=%h r=%h want ff 00", o_quotient, o_remainder);
      end
      repeat (3) @(negedge i_clock);
      checks++;
      if (o_overflow !== 1'b1 || o_finished !== 1'b0 || o_quotient !== 8'hFF) begin
         errors++; $display("FAIL overflow_hold: got ovf=%b fin=%b q=%h want 1 0 ff", o_overflow, o_finished, o_quotient);
      end
   endtask

   task automatic test_div_zero;
      int cyc, busy_n;
      start_op(16'h1234, 8'h00);
      wait_finished(cyc, busy_n);
      checks++;
      if (cyc !== 1 || o_divide_by_zero !== 1'b1 || o_overflow !== 1'b0) begin
         errors++; $display("FAIL dbz_flag: got lat=%0d dbz=%b ovf=%b want 1 1 0", cyc, o_divide_by_zero, o_overflow);
      end
      checks++;
      if (o_quotient !== 8'hFF || o_remainder !== 8'h00) begin
         errors++; $display("FAIL dbz_result: got q=%h r=%h want ff 00", o_quotient, o_remainder);
      end
   endtask

   task automatic test_back_to_back;
      int cyc, busy_n;
      start_op(16'h0FFF, 8'h10);
      cyc = 1;
      while (!o_finished && cyc < 40) begin
         if (cyc == 3) begin
            i_start = 1'b1; i_dividend = 16'h0064; i_divisor = 8'h03;
         end else begin
            i_start = 1'b0;
         end
         @(negedge i_clock);
         cyc++;
      end
      checks++;
      if (cyc !== 9 || o_quotient !== 8'd255 || o_remainder !== 8'd15) begin
         errors++; $display("FAIL b2b_first: got lat=%0d %0d r %0d want 9 255 r 15", cyc, o_quotient, o_remainder);
      end
      // Start again in the DONE cycle itself.
      i_start = 1'b1; i_dividend = 16'h0064; i_divisor = 8'h03;
      @(negedge i_clock);
      i_start = 1'b0;
      wait_finished(cyc, busy_n);
      checks++;
      if (cyc !== 9 || o_quotient !== 8'd33 || o_remainder !== 8'd1) begin
         errors++; $display("FAIL b2b_second: got lat=%0d %0d r %0d want 9 33 r 1", cyc, o_quotient, o_remainder);
      end
   endtask

   task automatic test_reset_mid_run;
      int cyc, busy_n, fin_seen;
      start_op(16'd100, 8'd7);
      repeat (3) @(negedge i_clock);
      i_reset = 1'b1;
      @(negedge i_clock);
      i_reset = 1'b0;
      checks++;
      if ({o_busy, o_finished, o_divide_by_zero, o_overflow, o_quotient, o_remainder} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got busy=%b fin=%b q=%0d r=%0d want all 0",
                  o_busy, o_finished, o_quotient, o_remainder);
      end
      fin_seen = 0;
      repeat (15) begin
         @(negedge i_clock);
         if (o_finished || o_busy) fin_seen++;
      end
      checks++;
      if (fin_seen !== 0) begin errors++; $display("FAIL midreset_idle: got %0d active cycles want 0", fin_seen); end
      start_op(16'd100, 8'd7);
      wait_finished(cyc, busy_n);
      checks++;
      if (cyc !== 9 || o_quotient !== 8'd14 || o_remainder !== 8'd2) begin
         errors++; $display("FAIL midreset_after: got lat=%0d %0d r %0d want 9 14 r 2", cyc, o_quotient, o_remainder);
      end
   endtask

   task automatic test_random;
      logic [2*BITS-1:0] dvd;
      logic [BITS-1:0]   dvs, eq, er;
      logic              edbz, eovf;
      int                elat, cyc, busy_n;
      for (int i = 0; i < 60; i++) begin
         dvs = ($urandom_range(0, 9) == 0) ? 8'd0 : BITS'($urandom_range(1, 255));
         dvd = 16'($urandom);
         if (dvs != 0 && $urandom_range(0, 3) != 0)
            dvd[2*BITS-1:BITS] = BITS'($urandom_range(0, int'(dvs) - 1));
         model(dvd, dvs, eq, er, edbz, eovf, elat);
         start_op(dvd, dvs);
         wait_finished(cyc, busy_n);
         checks++;
         if (o_quotient !== eq || o_remainder !== er || o_divide_by_zero !== edbz ||
             o_overflow !== eovf || cyc !== elat) begin
            errors++;
            $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d dbz=%b ovf=%b lat=%0d want q=%0d r=%0d dbz=%b ovf=%b lat=%0d",
                     i, dvd, dvs, o_quotient, o_remainder, o_divide_by_zero, o_overflow, cyc,
                     eq, er, edbz, eovf, elat);
         end
         if ($urandom_range(0, 1) == 1) @(negedge i_clock);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_overflow();
      test_div_zero();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
